// File: rtl/flags_unit_if.sv
// flags_unit_if: ALU/control-unit bus of the flags stage.
// Flag bit order within every 4-bit flag vector is Z, N, C, V from bit 0 up.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`define FLAGS_N 1
`define FLAGS_C 2
`define FLAGS_V 3
`endif

interface flags_unit_if #(
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);
    logic [3:0]    AluFlags;
    logic          FlagsWe;
    logic [3:0]    FlagsMask;
    logic          FlagsLoad;
    logic [3:0]    FlagsIn;
    logic          IntEnter;
    logic          IntReturn;
    logic          IntEnSet;
    logic          IntEnClr;
    logic          ErrClr;
    logic [3:0]    Cond;
    logic [3:0]    Flags;
    logic          CarryOut;
    logic          CondTrue;
    logic          IntEnable;
    logic [DW-1:0] StackDepth;
    logic          StackErr;
    modport master (
        output AluFlags, FlagsWe, FlagsMask, FlagsLoad, FlagsIn, IntEnter, IntReturn,
               IntEnSet, IntEnClr, ErrClr, Cond,
        input  Flags, CarryOut, CondTrue, IntEnable, StackDepth, StackErr
    );
    modport slave (
        input  AluFlags, FlagsWe, FlagsMask, FlagsLoad, FlagsIn, IntEnter, IntReturn,
               IntEnSet, IntEnClr, ErrClr, Cond,
        output Flags, CarryOut, CondTrue, IntEnable, StackDepth, StackErr
    );
endinterface

// File: rtl/flags_unit.sv
// flags_unit: Z/N/C/V flag register with masked ALU writes, branch condition
// evaluation and a LIFO save stack of {IE, Flags} for interrupt entry/return.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`define FLAGS_N 1
`define FLAGS_C 2
`define FLAGS_V 3
`endif

module flags_unit #(
    parameter int DEPTH = 4
) (
    input logic        Clock,
    input logic        nReset,
    flags_unit_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [3:0]    flags;
    logic          ie;
    logic          err;
    logic [DW-1:0] depth;
    logic [4:0]    stack [DEPTH];
    logic          full, empty, push, pop, stack_err;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          z, n, c, v;
    logic [7:0]    base;

    assign full      = depth == DW'(DEPTH);
    assign empty     = depth == '0;
    assign push      = bus.IntEnter && !full;
    assign pop       = bus.IntReturn && !bus.IntEnter && !empty;
    assign stack_err = (bus.IntEnter && full) || (bus.IntReturn && !bus.IntEnter && empty);
    assign wr_idx    = AW'(depth);
    assign rd_idx    = AW'(depth - 1'b1);

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            flags <= '0;
            ie    <= 1'b0;
            depth <= '0;
            err   <= 1'b0;
        end else begin
            if (pop)
                {ie, flags} <= stack[rd_idx];
            else begin
                if (bus.FlagsLoad)
                    flags <= bus.FlagsIn;
                else if (bus.FlagsWe)
                    flags <= (bus.FlagsMask & bus.AluFlags) | (~bus.FlagsMask & flags);
                if (bus.IntEnter)
                    ie <= 1'b0;
                else if (!bus.IntReturn && bus.IntEnClr)
                    ie <= 1'b0;
                else if (!bus.IntReturn && bus.IntEnSet)
                    ie <= 1'b1;
            end
            if (push)
                depth <= depth + 1'b1;
            else if (pop)
                depth <= depth - 1'b1;
            err <= stack_err ? 1'b1 : (bus.ErrClr ? 1'b0 : err);
        end
    end

    // Stack contents need no reset; depth alone defines what is valid.
    always_ff @(posedge Clock) begin
        if (nReset && push)
            stack[wr_idx] <= {ie, flags};
    end

    // Odd condition codes are the complement of the even code below them.
    assign z    = flags[`FLAGS_Z];
    assign n    = flags[`FLAGS_N];
    assign c    = flags[`FLAGS_C];
    assign v    = flags[`FLAGS_V];
    assign base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};

    assign bus.CondTrue   = base[bus.Cond[3:1]] ^ bus.Cond[0];
    assign bus.Flags      = flags;
    assign bus.CarryOut   = flags[`FLAGS_C];
    assign bus.IntEnable  = ie;
    assign bus.StackDepth = depth;
    assign bus.StackErr   = err;
endmodule

// File: tb/tb_flags_unit.sv
// tb_flags_unit: table vectors, directed interrupt sequences and random
// stimulus checked against a queue-based reference model.
module tb_flags_unit;
    localparam int DEPTH = 4;
    localparam int DW = $clog2(DEPTH + 1);

    logic Clock = 1'b0;
    logic nReset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    flags_unit_if #(.DEPTH(DEPTH)) bus ();
    flags_unit #(.DEPTH(DEPTH)) dut (.Clock(Clock), .nReset(nReset), .bus(bus));

    always #5 Clock = ~Clock;

    // Reference model: flags as a vector, stack as a queue of {IE, Flags}
    logic [3:0] m_flags;
    logic       m_ie, m_err;
    logic [4:0] m_stk [$];

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } cvec_t;
    cvec_t tv [$];

    function automatic logic cond_ref(logic [3:0] f, logic [3:0] cc);
        logic z, n, c, v;
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && n == v;
            4'd13: return z || n != v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] nf;
        logic       nie, ev;
        logic [4:0] top;
        if (!nReset) begin
            m_flags = '0; m_ie = 1'b0; m_err = 1'b0;
            m_stk.delete();
            return;
        end
        nf = m_flags; nie = m_ie; ev = 1'b0;
        if (bus.FlagsLoad) nf = bus.FlagsIn;
        else if (bus.FlagsWe)
            for (int i = 0; i < 4; i++) if (bus.FlagsMask[i]) nf[i] = bus.AluFlags[i];
        if (bus.IntEnter) begin
            if (m_stk.size() < DEPTH) m_stk.push_back({m_ie, m_flags});
            else ev = 1'b1;
            nie = 1'b0;
        end else if (bus.IntReturn) begin
            if (m_stk.size() > 0) begin
                top = m_stk.pop_back();
                nie = top[4];
                nf  = top[3:0];
            end else ev = 1'b1;
        end else if (bus.IntEnClr) nie = 1'b0;
        else if (bus.IntEnSet) nie = 1'b1;
        m_flags = nf; m_ie = nie;
        m_err = ev ? 1'b1 : (bus.ErrClr ? 1'b0 : m_err);
    endtask

    task automatic cyc();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        nReset = 1'b1;
        bus.AluFlags = '0; bus.FlagsWe = 0; bus.FlagsMask = '0; bus.FlagsLoad = 0;
        bus.FlagsIn = '0; bus.IntEnter = 0; bus.IntReturn = 0; bus.IntEnSet = 0;
        bus.IntEnClr = 0; bus.ErrClr = 0; bus.Cond = 4'd14;
    endtask

    task automatic check_all(string tag);
        chk({tag, ".flags"}, 8'(bus.Flags), 8'(m_flags));
        chk({tag, ".carry"}, 8'(bus.CarryOut), 8'(m_flags[2]));
        chk({tag, ".ie"}, 8'(bus.IntEnable), 8'(m_ie));
        chk({tag, ".depth"}, 8'(bus.StackDepth), 8'(m_stk.size()));
        chk({tag, ".err"}, 8'(bus.StackErr), 8'(m_err));
        chk({tag, ".cond"}, 8'(bus.CondTrue), 8'(cond_ref(m_flags, bus.Cond)));
    endtask

    task automatic do_reset();
        idle();
        nReset = 1'b0;
        cyc();
        idle();
    endtask

    task automatic load(logic [3:0] f);
        idle();
        bus.FlagsLoad = 1; bus.FlagsIn = f;
        cyc();
        idle();
    endtask

    initial begin
        tv = '{
            '{4'h6, 4'd8, 1'b1}, '{4'h6, 4'd10, 1'b0}, '{4'h6, 4'd11, 1'b1},
            '{4'h6, 4'd12, 1'b0}, '{4'h6, 4'd13, 1'b1}, '{4'h1, 4'd0, 1'b1},
            '{4'h0, 4'd1, 1'b1}, '{4'hA, 4'd10, 1'b1}, '{4'h5, 4'd8, 1'b0},
            '{4'h5, 4'd9, 1'b1}, '{4'h0, 4'd14, 1'b1}, '{4'hF, 4'd15, 1'b0},
            '{4'h8, 4'd6, 1'b1}, '{4'h8, 4'd12, 1'b0}, '{4'h4, 4'd3, 1'b0}
        };

        // Reset with a pending full write that must be ignored
        idle();
        nReset = 0; bus.FlagsWe = 1; bus.FlagsMask = 4'hF; bus.AluFlags = 4'hF;
        cyc();
        idle();
        chk("rst.flags", 8'(bus.Flags), 8'h0);
        chk("rst.ie", 8'(bus.IntEnable), 8'h0);
        chk("rst.depth", 8'(bus.StackDepth), 8'h0);
        chk("rst.err", 8'(bus.StackErr), 8'h0);
        #1 chk("rst.al", 8'(bus.CondTrue), 8'h1);
        bus.Cond = 4'd15;
        #1 chk("rst.nv", 8'(bus.CondTrue), 8'h0);

        // Masked write of Z,N only, then carry latency
        idle();
        bus.FlagsWe = 1; bus.AluFlags = 4'hF; bus.FlagsMask = 4'b0011;
        cyc();
        chk("mask.flags", 8'(bus.Flags), 8'h3);
        chk("mask.carry", 8'(bus.CarryOut), 8'h0);
        bus.FlagsMask = 4'hF; bus.AluFlags = 4'h4;
        #1 chk("carry.before", 8'(bus.CarryOut), 8'h0);
        cyc();
        idle();
        chk("carry.after", 8'(bus.CarryOut), 8'h1);

        // Condition vector table
        foreach (tv[k]) begin
            load(tv[k].flags);
            bus.Cond = tv[k].cond;
            #1 chk($sformatf("tv%0d", k), 8'(bus.CondTrue), 8'(tv[k].exp));
        end

        // Full sweep of codes against flag values
        for (int f = 0; f < 16; f++) begin
            load(4'(f));
            for (int cc = 0; cc < 16; cc++) begin
                bus.Cond = 4'(cc);
                #1 chk($sformatf("sweep f%0h c%0d", f, cc), 8'(bus.CondTrue),
                       8'(cond_ref(4'(f), 4'(cc))));
            end
        end

        // Nested interrupts
        do_reset();
        bus.FlagsLoad = 1; bus.FlagsIn = 4'h5; bus.IntEnSet = 1;
        cyc(); idle();
        bus.IntEnter = 1; cyc(); idle();
        check_all("nest.enter1");
        bus.FlagsLoad = 1; bus.FlagsIn = 4'hA; bus.IntEnSet = 1;
        cyc(); idle();
        bus.IntEnter = 1; cyc(); idle();
        chk("nest.depth2", 8'(bus.StackDepth), 8'h2);
        bus.IntReturn = 1; cyc(); idle();
        chk("nest.ret1.flags", 8'(bus.Flags), 8'hA);
        chk("nest.ret1.ie", 8'(bus.IntEnable), 8'h1);
        chk("nest.ret1.depth", 8'(bus.StackDepth), 8'h1);
        bus.IntReturn = 1; cyc(); idle();
        chk("nest.ret2.flags", 8'(bus.Flags), 8'h5);
        chk("nest.ret2.ie", 8'(bus.IntEnable), 8'h1);
        chk("nest.ret2.depth", 8'(bus.StackDepth), 8'h0);

        // Overflow then underflow
        do_reset();
        load(4'h1);
        for (int i = 0; i < 5; i++) begin
            bus.IntEnter = 1; bus.FlagsLoad = 1; bus.FlagsIn = 4'(i + 2);
            cyc();
            chk($sformatf("ovf.err%0d", i), 8'(bus.StackErr), 8'(i == 4));
        end
        idle();
        chk("ovf.depth", 8'(bus.StackDepth), 8'h4);
        chk("ovf.live", 8'(bus.Flags), 8'h6);
        bus.ErrClr = 1; cyc(); idle();
        chk("ovf.clr", 8'(bus.StackErr), 8'h0);
        for (int i = 0; i < 4; i++) begin
            bus.IntReturn = 1; cyc();
            chk($sformatf("pop%0d", i), 8'(bus.Flags), 8'(4 - i));
        end
        bus.IntReturn = 1; cyc(); idle();
        chk("udf.flags", 8'(bus.Flags), 8'h1);
        chk("udf.err", 8'(bus.StackErr), 8'h1);
        bus.IntReturn = 1; bus.ErrClr = 1; cyc(); idle();
        chk("udf.errwins", 8'(bus.StackErr), 8'h1);
        check_all("udf");

        // Simultaneous events and mid-sequence reset
        do_reset();
        load(4'h3);
        bus.IntEnter = 1; bus.IntReturn = 1; cyc(); idle();
        chk("both.depth", 8'(bus.StackDepth), 8'h1);
        bus.IntReturn = 1; bus.FlagsWe = 1; bus.FlagsMask = 4'hF; bus.AluFlags = 4'hC;
        cyc(); idle();
        chk("popwins.flags", 8'(bus.Flags), 8'h3);
        bus.IntEnter = 1; bus.FlagsWe = 1; bus.FlagsMask = 4'hF; bus.AluFlags = 4'h9;
        cyc(); idle();
        chk("enterwe.live", 8'(bus.Flags), 8'h9);
        bus.IntReturn = 1; cyc(); idle();
        chk("enterwe.saved", 8'(bus.Flags), 8'h3);
        bus.IntEnSet = 1; cyc(); idle();
        for (int i = 0; i < 3; i++) begin bus.IntEnter = 1; cyc(); end
        idle();
        chk("mid.depth3", 8'(bus.StackDepth), 8'h3);
        bus.IntEnSet = 1; cyc(); idle();
        nReset = 0; bus.IntEnter = 1; cyc(); idle();
        chk("mid.depth", 8'(bus.StackDepth), 8'h0);
        chk("mid.ie", 8'(bus.IntEnable), 8'h0);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            nReset        = $urandom_range(0, 60) != 0;
            bus.AluFlags  = 4'($urandom);
            bus.FlagsWe   = 1'($urandom);
            bus.FlagsMask = 4'($urandom);
            bus.FlagsLoad = $urandom_range(0, 4) == 0;
            bus.FlagsIn   = 4'($urandom);
            bus.IntEnter  = $urandom_range(0, 4) == 0;
            bus.IntReturn = $urandom_range(0, 4) == 0;
            bus.IntEnSet  = $urandom_range(0, 3) == 0;
            bus.IntEnClr  = $urandom_range(0, 3) == 0;
            bus.ErrClr    = $urandom_range(0, 5) == 0;
            bus.Cond      = 4'($urandom);
            cyc();
            check_all($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/flags_unit.md
Name: flags_unit

Overview:
- Status/flags stage directly downstream of the ALU. Captures the ALU's 4-bit Z/N/C/V flags under a per-flag write mask.
- Feeds the stored carry back to the ALU CarryIn for ADC/SUC.
- Evaluates 4-bit branch condition codes for the control unit.
- Saves and restores flags plus the interrupt-enable bit on a small hardware stack for interrupt entry and return.

Parameters:
- DEPTH, 4, number of {IE, Flags} entries on the interrupt save stack (>=1).
- DW, $clog2(DEPTH+1), width of StackDepth (derived; not overridden).

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- nReset  input  1  synchronous active-low reset.
- AluFlags  input  4  flags from ALU; bit order per `FLAGS_Z/N/C/V` defines.
- FlagsWe  input  1  write AluFlags into flags register under FlagsMask.
- FlagsMask  input  4  per-flag write enable (same bit order); logic ops leave C/V unmasked=0.
- FlagsLoad  input  1  load FlagsIn into all four flags (software restore); ignores mask.
- FlagsIn  input  4  data for FlagsLoad.
- IntEnter  input  1  interrupt entry: push {IE, Flags}, clear IE.
- IntReturn  input  1  interrupt return: pop {IE, Flags}.
- IntEnSet  input  1  set IE.
- IntEnClr  input  1  clear IE.
- ErrClr  input  1  clear sticky StackErr.
- Cond  input  4  condition code to evaluate.
- Flags  output  4  registered flags.
- CarryOut  output  1  registered C flag; drives ALU CarryIn.
- CondTrue  output  1  combinational result of Cond against registered Flags.
- IntEnable  output  1  registered interrupt-enable bit.
- StackDepth  output  DW  number of occupied stack entries.
- StackErr  output  1  sticky overflow/underflow error.

Behaviour:
- Reset (nReset low at a clock edge, any cycle including mid-interrupt sequence):
  - Flags=0, IE=0, StackDepth=0, StackErr=0.
  - Stack contents are don't-care.
  - Reset overrides every other input.
- Latency: all writes are visible on the outputs the cycle after the enabling edge. CarryOut equals Flags[C] at all times; it is never the in-flight AluFlags.
- Flag update priority per cycle: IntReturn pop > FlagsLoad > FlagsWe.
  - FlagsWe: Flags[i] <= FlagsMask[i] ? AluFlags[i] : Flags[i].
  - FlagsLoad: Flags <= FlagsIn.
- IntEnter (IntReturn ignored if both are high in the same cycle):
  - If StackDepth<DEPTH: push {IE, Flags}, using pre-edge values, and StackDepth+1.
  - If StackDepth==DEPTH: no push, depth unchanged, StackErr<=1.
  - In both cases IE<=0.
  - FlagsWe/FlagsLoad still update Flags in the same cycle; the completing instruction's flags are kept live.
- IntReturn (IntEnter low):
  - If StackDepth>0: pop top entry, Flags<=saved flags, IE<=saved IE, StackDepth-1. FlagsWe/FlagsLoad are ignored that cycle.
  - If StackDepth==0: no state change except StackErr<=1; FlagsWe/FlagsLoad apply normally.
- IE control:
  - IntEnSet/IntEnClr are ignored in any cycle with IntEnter or IntReturn high.
  - If both are high, IntEnClr wins.
- StackErr: sticky. Cleared only by reset or ErrClr. If an error and ErrClr occur in the same cycle, the error wins (StackErr=1).
- Stack is LIFO: entry DEPTH-1 is the last usable; no wrap-around.
- CondTrue (N,Z,C,V from registered Flags):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- No X may propagate to outputs after reset, regardless of AluFlags content while FlagsWe=0.

Test Plan:
1. Reset: hold nReset=0 one edge with FlagsWe=1, AluFlags=4'hF -> Flags=0, IE=0, StackDepth=0, StackErr=0, CondTrue(Cond=14)=1, CondTrue(Cond=15)=0.
2. Masked write: Flags=0; FlagsWe=1, AluFlags=4'hF, FlagsMask={Z,N only} -> next cycle Z=N=1, C=V=0, CarryOut=0. Then mask all, C=1 -> CarryOut=1 one cycle after the edge, not before.
3. Conditions: set N=1, V=0, Z=0, C=1 -> Cond 8(HI)=1, 10(GE)=0, 11(LT)=1, 12(GT)=0, 13(LE)=1. Sweep all 16 codes against all 16 flag values versus a reference model.
4. Nested interrupts, DEPTH=4:
   - IE=1, Flags=4'h5: IntEnter.
   - Change Flags to 4'hA, IntEnSet: IntEnter.
   - IntReturn -> Flags=4'hA, IE=1, depth 1.
   - IntReturn -> Flags=4'h5, IE=1, depth 0.
5. Overflow/underflow:
   - 5 IntEnter pulses -> depth=4, StackErr=1 after the 5th, top entry intact.
   - ErrClr, then 5 IntReturn pulses -> 4 correct pops, 5th sets StackErr, Flags unchanged.
   - ErrClr concurrent with an error -> StackErr stays 1.
6. Simultaneous events and mid-sequence reset:
   - IntEnter+IntReturn in one cycle -> push only.
   - IntReturn+FlagsWe -> popped flags win.
   - IntEnter+FlagsWe -> pushed value is the old flags, live Flags=AluFlags.
   - nReset=0 with depth=3 -> depth=0, IE=0 next cycle.
